imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 1024, the largest accepted program length in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 16, the width of the instruction-memory word address.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rstIn  input  1  reset; synchronous, active-high.
REQ-005 Port byteValid  input  1  upstream byte-stream valid.
REQ-006 Port byteData  input  8  upstream byte value.
REQ-007 Port byteReady  output  1  loader can accept a byte; a transfer occurs when byteValid and byteReady are both high at a rising clk edge.
REQ-008 Port wrEn  output  1  instruction-memory write strobe.
REQ-009 Port wrAddr  output  ADDR_W  instruction-memory word address.
REQ-010 Port wrData  output  32  instruction word.
REQ-011 Port cpuRst  output  1  active-high hold-in-reset for the CPU controller.
REQ-012 Port done  output  1  load completed successfully.
REQ-013 Port err  output  1  load aborted.

Function
REQ-014 The FSM SHALL have the states HDR_HI, HDR_LO, DATA, CHK (only when the macro is defined), DONE and ERR.
REQ-015 The stream format SHALL be a 16-bit big-endian word count N (HDR_HI byte, then HDR_LO byte), followed by 4*N data bytes, each word big-endian (first byte goes to bits 31:24).
REQ-016 byteReady SHALL be 1 in HDR_HI, HDR_LO, DATA and CHK, and 0 in DONE, in ERR, and in any cycle where rstIn=1.
REQ-017 After HDR_LO is accepted: if N>MAX_WORDS, go to ERR; if N=0, go to CHK (macro defined) or DONE (macro undefined); otherwise go to DATA.
REQ-018 On acceptance of the 4th byte of word k, the outputs SHALL register wrEn=1, wrAddr=k, wrData=the assembled word, valid in the next cycle only (1-cycle latency, 1-cycle pulse).
REQ-019 Word index k SHALL start at 0 and increment by 1 per word; wrAddr SHALL never exceed N-1.
REQ-020 No stall SHALL occur: byteReady stays 1 during the wrEn cycle, so back-to-back bytes every cycle SHALL be accepted.
REQ-021 After the last word (k=N-1), the FSM SHALL go to CHK (macro defined) or DONE (macro undefined).
REQ-022 done=1 and cpuRst=0 SHALL first appear in the cycle after the final wrEn pulse, or after the final accepted byte when no data follows.
REQ-023 DONE and ERR SHALL be terminal until rstIn; byteValid SHALL be ignored in both states.
REQ-024 In ERR: err=1, cpuRst=1, wrEn=0.
REQ-025 When byteValid=0, the FSM, the byte position and the word index SHALL hold.

Reset
REQ-026 While rstIn=1, the block SHALL drive: state=HDR_HI, byte position=0, word index=0, wrEn=0, wrAddr=0, wrData=0, cpuRst=1, done=0, err=0, byteReady=0; when defined, the checksum accumulator is also 0.
REQ-027 A reset asserted mid-load, in any state, SHALL discard partially assembled words, and no byte SHALL be accepted in that cycle.
REQ-028 byteReady=1 SHALL appear in the first cycle with rstIn=0.

Configuration
REQ-029 The macro IMEM_LOADER_CHECKSUM_EN SHALL control the checksum feature as follows.
- Defined: keep a running XOR of all header and data bytes; in CHK, accept one byte; if it equals the XOR, go to DONE, otherwise go to ERR.
- Undefined: no CHK state and no accumulator; the stream ends after the last data byte.

Verification
REQ-030 Load test: rstIn 1 for 2 cycles, then stream 00 02 DE AD BE EF 01 23 45 67 (plus 20 if the macro is defined), one byte per cycle -> wrEn pulses at addr 0 with 0xDEADBEEF and at addr 1 with 0x01234567; done=1 and cpuRst=0 follow at the cycle given in REQ-022.
REQ-031 Oversize header: header 04 01 with MAX_WORDS=1024 -> err=1 the cycle after HDR_LO, byteReady=0, no wrEn, cpuRst stays 1.
REQ-032 Gapped stream: the REQ-030 stream with byteValid toggling 1/0 each cycle -> identical writes and result; no duplicated or dropped bytes.
REQ-033 Mid-load reset: assert rstIn after byte 5 of REQ-030, then replay the full stream -> only the replayed writes occur, starting at addr 0.
REQ-034 Empty and bad checksum: header 00 00 (plus 00 if the macro is defined) -> done=1 with no wrEn; with the macro defined, checksum 21 in REQ-030 -> err=1 and done=0.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Receives a program image as a byte stream and writes it, word by word,
//   into the instruction memory. The CPU is held in reset until the whole
//   image has been written. A malformed image (too many words, or a bad
//   checksum when that option is built in) parks the loader in an error state
//   with the CPU still held in reset.
//
//   Stream layout: 16-bit big-endian word count N, then 4*N data bytes, each
//   word big-endian (first byte lands in bits 31:24).
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN - when defined, the loader keeps a running XOR of
//   every header and data byte. After the data, one extra byte is expected;
//   the load succeeds only if that byte equals the running XOR.
//
// Ports:
//   clk        in   1       single clock, rising edge
//   rstIn      in   1       synchronous active-high reset
//   byteValid  in   1       upstream byte valid
//   byteData   in   8       upstream byte value
//   byteReady  out  1       loader can accept a byte this cycle
//   wrEn       out  1       instruction-memory write strobe (1-cycle pulse)
//   wrAddr     out  ADDR_W  instruction-memory word address
//   wrData     out  32      instruction word
//   cpuRst     out  1       holds the CPU controller in reset
//   done       out  1       load completed successfully
//   err        out  1       load aborted
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rstIn,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [31:0]       wrData,
  output logic              cpuRst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  // Where the loader goes once the last data word (or an empty header) is in.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t EndState = CHK;
`else
  localparam state_t EndState = DONE;
`endif

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [7:0]          nHi_q, nHi_d;
  logic [15:0]         lastIdx_q, lastIdx_d;
  logic [15:0]         wordCnt_q, wordCnt_d;
  logic [1:0]          bytePos_q, bytePos_d;
  logic [23:0]         shift_q, shift_d;
  logic                wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
  logic [31:0]         wrData_q, wrData_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                accept;
  logic [15:0]         nWords;
  logic                doneInt;

  // Ready is withheld during reset so that a byte offered in a reset cycle is
  // never consumed; the terminal states stop the stream for good.
  assign byteReady = !rstIn && (state_q != DONE) && (state_q != ERR);
  assign accept    = byteValid && byteReady;
  assign nWords    = {nHi_q, byteData};

  // done is held back while the final write pulse is still on the bus, so the
  // CPU is only released once the last word has actually been written.
  assign doneInt = !rstIn && (state_q == DONE) && !wrEn_q;

  // Outputs are forced to their reset values combinationally while rstIn is
  // high, so they are correct even in the very first reset cycle.
  assign wrEn   = !rstIn && wrEn_q;
  assign wrAddr = rstIn ? '0 : wrAddr_q;
  assign wrData = rstIn ? '0 : wrData_q;
  assign done   = doneInt;
  assign err    = !rstIn && (state_q == ERR);
  assign cpuRst = !doneInt;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstIn) begin
      state_q   <= HDR_HI;
      nHi_q     <= '0;
      lastIdx_q <= '0;
      wordCnt_q <= '0;
      bytePos_q <= '0;
      shift_q   <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      nHi_q     <= nHi_d;
      lastIdx_q <= lastIdx_d;
      wordCnt_q <= wordCnt_d;
      bytePos_q <= bytePos_d;
      shift_q   <= shift_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state logic: everything holds unless a byte is accepted. The write
  // strobe is a single-cycle pulse, so it defaults low every cycle.
  always_comb begin
    state_d   = state_q;
    nHi_d     = nHi_q;
    lastIdx_d = lastIdx_q;
    wordCnt_d = wordCnt_q;
    bytePos_d = bytePos_q;
    shift_d   = shift_q;
    wrEn_d    = 1'b0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (accept && (state_q != CHK)) begin
      csum_d = csum_q ^ byteData;
    end
`endif

    if (accept) begin
      case (state_q)
        HDR_HI: begin
          nHi_d   = byteData;
          state_d = HDR_LO;
        end
        HDR_LO: begin
          // Storing N-1 lets the last-word test be a plain equality.
          lastIdx_d = nWords - 16'd1;
          wordCnt_d = '0;
          bytePos_d = '0;
          if ({1'b0, nWords} > MaxWords) begin
            state_d = ERR;
          end else if (nWords == 16'd0) begin
            state_d = EndState;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (bytePos_q == 2'd3) begin
            wrEn_d    = 1'b1;
            wrAddr_d  = ADDR_W'(wordCnt_q);
            wrData_d  = {shift_q, byteData};
            bytePos_d = '0;
            wordCnt_d = wordCnt_q + 16'd1;
            if (wordCnt_q == lastIdx_q) begin
              state_d = EndState;
            end
          end else begin
            shift_d   = {shift_q[15:0], byteData};
            bytePos_d = bytePos_q + 2'd1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          state_d = (byteData == csum_q) ? DONE : ERR;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Expected memory writes are derived from the
// byte stream as it is driven and queued; every cycle the DUT write port is
// compared against the head of that queue.
// Honors IMEM_LOADER_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic              clk;
  logic              rstIn;
  logic              byteValid;
  logic [7:0]        byteData;
  logic              byteReady;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       wrData;
  logic              cpuRst;
  logic              done;
  logic              err;

  int   checks;
  int   errors;
  wr_t  expQ[$];
  logic [7:0] stream[$];

  imem_loader #(
    .MAX_WORDS(1024),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rstIn(rstIn),
    .byteValid(byteValid),
    .byteData(byteData),
    .byteReady(byteReady),
    .wrEn(wrEn),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .cpuRst(cpuRst),
    .done(done),
    .err(err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, and score any write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wrEn === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wrEn", {31'd0, wrEn}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wrAddr", {16'd0, wrAddr}, {16'd0, e.addr});
        checkOutput("wrData", wrData, e.data);
      end
    end
  endtask

  // Present one byte for exactly one cycle. When this byte completes a data
  // word of the current stream, the expected write is queued first.
  task automatic applyStimulus(input int idx);
    int   n;
    int   d;
    wr_t  e;
    n = {stream[0], stream[1]};
    d = idx - 2;
    if (idx >= 2 && (d % 4) == 3 && (d / 4) < n) begin
      e.addr = 16'(d / 4);
      e.data = {stream[idx-3], stream[idx-2], stream[idx-1], stream[idx]};
      expQ.push_back(e);
    end
    byteValid = 1'b1;
    byteData  = stream[idx];
    tick();
    byteValid = 1'b0;
  endtask

  // Drive the first 'upto' bytes of the stream, optionally with an idle cycle
  // before every byte after the first.
  task automatic sendStream(input bit gap, input int upto);
    for (int i = 0; i < upto; i++) begin
      if (gap && i > 0) begin
        byteData = 8'hFF;
        tick();
      end
      applyStimulus(i);
    end
  endtask

  // Reset for two cycles, checking the held values, then release.
  task automatic doReset();
    rstIn     = 1'b1;
    byteValid = 1'b0;
    #1;
    checkOutput("rst_byteReady", {31'd0, byteReady}, 32'd0);
    checkOutput("rst_cpuRst", {31'd0, cpuRst}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    expQ.delete();
    rstIn = 1'b0;
    #1;
    checkOutput("post_rst_byteReady", {31'd0, byteReady}, 32'd1);
    checkOutput("post_rst_wrAddr", {16'd0, wrAddr}, 32'd0);
    checkOutput("post_rst_wrData", wrData, 32'd0);
    checkOutput("post_rst_err", {31'd0, err}, 32'd0);
  endtask

  // Called right after the last byte's edge: verify the success handoff.
  task automatic finishCheck(input string tag, input bit hadData);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (hadData) begin
      checkOutput({tag, "_done_during_wr"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_cpuRst_during_wr"}, {31'd0, cpuRst}, 32'd1);
      tick();
    end
`endif
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_cpuRst"}, {31'd0, cpuRst}, 32'd0);
    checkOutput({tag, "_byteReady"}, {31'd0, byteReady}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_pending_writes"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic loadGoodStream();
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
               8'h01, 8'h23, 8'h45, 8'h67};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h20);
`endif
  endtask

  // Directed sequence of load scenarios.
  initial begin
    checks    = 0;
    errors    = 0;
    rstIn     = 1'b1;
    byteValid = 1'b0;
    byteData  = 8'h00;

    // Back-to-back load of two words.
    $display("[TB] load test");
    doReset();
    loadGoodStream();
    sendStream(1'b0, stream.size());
    finishCheck("load", 1'b1);
    // DONE ignores further bytes.
    byteValid = 1'b1;
    byteData  = 8'h5A;
    tick();
    tick();
    byteValid = 1'b0;
    checkOutput("done_hold", {31'd0, done}, 32'd1);

    // Oversize header goes straight to ERR.
    $display("[TB] oversize header");
    doReset();
    stream = '{8'h04, 8'h01};
    sendStream(1'b0, 2);
    checkOutput("ovf_err", {31'd0, err}, 32'd1);
    checkOutput("ovf_byteReady", {31'd0, byteReady}, 32'd0);
    checkOutput("ovf_cpuRst", {31'd0, cpuRst}, 32'd1);
    checkOutput("ovf_done", {31'd0, done}, 32'd0);
    byteValid = 1'b1;
    byteData  = 8'h55;
    for (int i = 0; i < 6; i++) tick();
    byteValid = 1'b0;
    checkOutput("ovf_err_hold", {31'd0, err}, 32'd1);
    checkOutput("ovf_cpuRst_hold", {31'd0, cpuRst}, 32'd1);

    // Same stream with byteValid toggling every cycle.
    $display("[TB] gapped stream");
    doReset();
    loadGoodStream();
    sendStream(1'b1, stream.size());
    finishCheck("gap", 1'b1);

    // Reset after five bytes, with a byte offered during reset, then replay.
    $display("[TB] mid-load reset");
    doReset();
    loadGoodStream();
    sendStream(1'b0, 5);
    rstIn     = 1'b1;
    byteValid = 1'b1;
    byteData  = 8'hAA;
    #1;
    checkOutput("midrst_byteReady", {31'd0, byteReady}, 32'd0);
    checkOutput("midrst_cpuRst", {31'd0, cpuRst}, 32'd1);
    doReset();
    sendStream(1'b0, stream.size());
    finishCheck("replay", 1'b1);

    // Empty image.
    $display("[TB] empty image");
    doReset();
    stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    sendStream(1'b0, stream.size());
    finishCheck("empty", 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte aborts after both writes.
    $display("[TB] bad checksum");
    doReset();
    loadGoodStream();
    stream[stream.size()-1] = 8'h21;
    sendStream(1'b0, stream.size());
    checkOutput("badck_err", {31'd0, err}, 32'd1);
    checkOutput("badck_done", {31'd0, done}, 32'd0);
    checkOutput("badck_cpuRst", {31'd0, cpuRst}, 32'd1);
    checkOutput("badck_pending", 32'(expQ.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
